// File: rtl/can_tx_mb_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// can_tx_mb_sched: CAN transmit-mailbox scheduler, lowest ID first.  Rev 1.0
// Optional sticky interrupt enabled by defining CAN_TX_MB_SCHED_IRQ_EN.
// ----------------------------------------------------------------------------
module can_tx_mb_sched #(
   parameter int NUM_MB    = 4,
   parameter int MAX_RETRY = 3
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_n,
   input  logic                 en_i,
   input  logic [NUM_MB-1:0]    mb_req_i,
   input  logic [NUM_MB-1:0]    mb_abort_i,
   input  logic [NUM_MB*11-1:0] mb_id_i,
   output logic                 tx_start_o,
   output logic [2:0]           tx_sel_o,
   output logic [10:0]          tx_id_o,
   input  logic                 tx_done_i,
   input  logic                 tx_arb_lost_i,
   input  logic                 tx_err_i,
   output logic [NUM_MB-1:0]    mb_pending_o,
   output logic [NUM_MB-1:0]    mb_done_o,
   output logic [NUM_MB-1:0]    mb_fail_o,
   output logic                 busy_o,
`ifdef CAN_TX_MB_SCHED_IRQ_EN
   input  logic                 irq_clr_i,
`endif
   output logic                 irq_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_START  = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [NUM_MB-1:0]   pending_q, pending_d;
   logic [2:0]          sel_q, sel_d;
   logic [10:0]         id_q, id_d;
   logic [3:0]          retry_q, retry_d;
   logic                requeue_q, requeue_d;
   logic                abort_flag_q, abort_flag_d;
   logic                tx_start_q, tx_start_d;
   logic [NUM_MB-1:0]   done_q, done_d;
   logic [NUM_MB-1:0]   fail_q, fail_d;
   logic                busy_q, busy_d;
   logic                irq_q, irq_d;

   logic [NUM_MB-1:0]   cand;
   logic                win_found;
   logic [2:0]          win_idx;
   logic [10:0]         win_id;
   logic [NUM_MB-1:0]   sel_oh;
   logic [NUM_MB-1:0]   abort_hit;
   logic                abort_now;
   logic                retry_exceed;
   logic [3:0]          retry_inc;

   // Strict less-than keeps the lower index on equal IDs.
   always_comb begin
      cand      = pending_q & ~mb_abort_i;
      win_found = 1'b0;
      win_idx   = 3'd0;
      win_id    = 11'd0;
      for (int k = 0; k < NUM_MB; k++) begin
         if (cand[k] && (!win_found || (mb_id_i[11*k +: 11] < win_id))) begin
            win_found = 1'b1;
            win_idx   = 3'(k);
            win_id    = mb_id_i[11*k +: 11];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_MB; k++) begin
         sel_oh[k] = ((state_q == S_START) || (state_q == S_WAIT)) && (sel_q == 3'(k));
      end
   end

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      id_d         = id_q;
      retry_d      = retry_q;
      requeue_d    = requeue_q;
      abort_flag_d = abort_flag_q;
      tx_start_d   = 1'b0;
      done_d       = '0;

      abort_hit    = mb_abort_i & pending_q;
      abort_now    = abort_flag_q | (|(abort_hit & sel_oh));
      retry_exceed = ({1'b0, retry_q} + 5'd1) > 5'(MAX_RETRY);
      retry_inc    = (retry_q == 4'hF) ? 4'hF : retry_q + 4'd1;

      // The active frame is already on the bus, so its abort is only flagged.
      pending_d = (pending_q | (mb_req_i & ~mb_abort_i)) & ~(abort_hit & ~sel_oh);
      fail_d    = abort_hit & ~sel_oh;
      if (|(abort_hit & sel_oh)) begin
         abort_flag_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            abort_flag_d = 1'b0;
            requeue_d    = 1'b0;
            if (en_i && (|pending_q)) begin
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            requeue_d = 1'b0;
            if (win_found) begin
               sel_d        = win_idx;
               id_d         = win_id;
               abort_flag_d = 1'b0;
               tx_start_d   = 1'b1;
               state_d      = S_START;
               if (!(requeue_q && (win_idx == sel_q))) begin
                  retry_d = 4'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done_i) begin
               pending_d    = pending_d & ~sel_oh;
               done_d       = sel_oh;
               abort_flag_d = 1'b0;
               state_d      = S_IDLE;
            end else if ((tx_err_i && (abort_now || retry_exceed)) ||
                         (tx_arb_lost_i && abort_now)) begin
               pending_d    = pending_d & ~sel_oh;
               fail_d       = fail_d | sel_oh;
               abort_flag_d = 1'b0;
               state_d      = S_IDLE;
            end else if (tx_err_i) begin
               retry_d   = retry_inc;
               requeue_d = 1'b1;
               state_d   = S_SELECT;
            end else if (tx_arb_lost_i) begin
               requeue_d = 1'b1;
               state_d   = S_SELECT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);

`ifdef CAN_TX_MB_SCHED_IRQ_EN
      if ((|done_q) || (|fail_q)) begin
         irq_d = 1'b1;
      end else if (irq_clr_i) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
`else
      irq_d = 1'b0;
`endif
   end

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q      <= S_IDLE;
         pending_q    <= '0;
         sel_q        <= 3'd0;
         id_q         <= 11'd0;
         retry_q      <= 4'd0;
         requeue_q    <= 1'b0;
         abort_flag_q <= 1'b0;
         tx_start_q   <= 1'b0;
         done_q       <= '0;
         fail_q       <= '0;
         busy_q       <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         pending_q    <= pending_d;
         sel_q        <= sel_d;
         id_q         <= id_d;
         retry_q      <= retry_d;
         requeue_q    <= requeue_d;
         abort_flag_q <= abort_flag_d;
         tx_start_q   <= tx_start_d;
         done_q       <= done_d;
         fail_q       <= fail_d;
         busy_q       <= busy_d;
         irq_q        <= irq_d;
      end
   end

   assign tx_start_o   = tx_start_q;
   assign tx_sel_o     = sel_q;
   assign tx_id_o      = id_q;
   assign mb_pending_o = pending_q;
   assign mb_done_o    = done_q;
   assign mb_fail_o    = fail_q;
   assign busy_o       = busy_q;
   assign irq_o        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_mb_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_can_tx_mb_sched: directed self-checking bench for can_tx_mb_sched. Rev 1.0
// ----------------------------------------------------------------------------
module tb_can_tx_mb_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  mb_req = '0;
   logic [3:0]  mb_abort = '0;
   logic [43:0] mb_id = '0;
   logic        tx_done = 1'b0;
   logic        tx_arb = 1'b0;
   logic        tx_err = 1'b0;
   logic        tx_start;
   logic [2:0]  tx_sel;
   logic [10:0] tx_id;
   logic [3:0]  mb_pending;
   logic [3:0]  mb_done;
   logic [3:0]  mb_fail;
   logic        busy;
   logic        irq;
`ifdef CAN_TX_MB_SCHED_IRQ_EN
   logic        irq_clr = 1'b0;
`endif

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   can_tx_mb_sched #(.NUM_MB(4), .MAX_RETRY(3)) dut (
      .wb_clk_i      (clk),
      .wb_rst_n      (rst_n),
      .en_i          (en),
      .mb_req_i      (mb_req),
      .mb_abort_i    (mb_abort),
      .mb_id_i       (mb_id),
      .tx_start_o    (tx_start),
      .tx_sel_o      (tx_sel),
      .tx_id_o       (tx_id),
      .tx_done_i     (tx_done),
      .tx_arb_lost_i (tx_arb),
      .tx_err_i      (tx_err),
      .mb_pending_o  (mb_pending),
      .mb_done_o     (mb_done),
      .mb_fail_o     (mb_fail),
      .busy_o        (busy),
`ifdef CAN_TX_MB_SCHED_IRQ_EN
      .irq_clr_i     (irq_clr),
`endif
      .irq_o         (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge; pulse inputs driven before the edge last exactly one cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      mb_req   = '0;
      mb_abort = '0;
      tx_done  = 1'b0;
      tx_arb   = 1'b0;
      tx_err   = 1'b0;
`ifdef CAN_TX_MB_SCHED_IRQ_EN
      irq_clr  = 1'b0;
`endif
   endtask

   task automatic wait_start();
      int n = 0;
      while (!tx_start && n < 20) begin
         tick();
         n++;
      end
      check("start_seen", 32'(tx_start), 32'd1);
   endtask

   task automatic count_starts(input int cycles, output int starts);
      starts = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (tx_start) starts++;
      end
   endtask

   task automatic do_frame(input logic [2:0] exp_sel, input logic [10:0] exp_id);
      wait_start();
      check("frame_sel", 32'(tx_sel), 32'(exp_sel));
      check("frame_id", 32'(tx_id), 32'(exp_id));
      tick();
      tx_done = 1'b1;
      tick();
      check("frame_done", 32'(mb_done), 32'(4'b0001 << exp_sel));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int st;

      tick();
      tick();
      check("rst_start", 32'(tx_start), 32'd0);
      check("rst_sel", 32'(tx_sel), 32'd0);
      check("rst_id", 32'(tx_id), 32'd0);
      check("rst_pending", 32'(mb_pending), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1;
      en    = 1'b1;
      tick();

      // Single frame with exact latency
      mb_id  = {11'h7FF, 11'h7FF, 11'h7FF, 11'h123};
      mb_req = 4'b0001;
      tick();
      check("t1_pend_E", 32'(mb_pending), 32'h1);
      check("t1_start_E", 32'(tx_start), 32'd0);
      tick();
      check("t1_busy_E1", 32'(busy), 32'd1);
      check("t1_start_E1", 32'(tx_start), 32'd0);
      tick();
      check("t1_start_E2", 32'(tx_start), 32'd1);
      check("t1_sel", 32'(tx_sel), 32'd0);
      check("t1_id", 32'(tx_id), 32'h123);
      tick();
      check("t1_start_E3", 32'(tx_start), 32'd0);
      tx_done = 1'b1;
      tick();
      check("t1_done", 32'(mb_done), 32'h1);
      check("t1_pend0", 32'(mb_pending), 32'h0);
      check("t1_busy0", 32'(busy), 32'd0);
      tick();
      check("t1_done_clr", 32'(mb_done), 32'h0);
`ifdef CAN_TX_MB_SCHED_IRQ_EN
      check("irq_set", 32'(irq), 32'd1);
      tick();
      check("irq_hold", 32'(irq), 32'd1);
      irq_clr = 1'b1;
      tick();
      check("irq_clr", 32'(irq), 32'd0);
`else
      check("irq_tied", 32'(irq), 32'd0);
`endif

      // Priority order with tie to lower index
      mb_id  = {11'h7FF, 11'h050, 11'h050, 11'h200};
      mb_req = 4'b1111;
      tick();
      do_frame(3'd1, 11'h050);
      do_frame(3'd2, 11'h050);
      do_frame(3'd0, 11'h200);
      do_frame(3'd3, 11'h7FF);
      tick();
      check("prio_pend0", 32'(mb_pending), 32'h0);

      // Arbitration loss requeue
      mb_id  = {11'h7FF, 11'h010, 11'h7FF, 11'h300};
      mb_req = 4'b0001;
      tick();
      wait_start();
      check("arb_first_sel", 32'(tx_sel), 32'd0);
      tick();
      mb_req = 4'b0100;
      tick();
      tx_arb = 1'b1;
      tick();
      wait_start();
      check("arb_re_sel", 32'(tx_sel), 32'd2);
      check("arb_re_id", 32'(tx_id), 32'h010);
      check("arb_pend", 32'(mb_pending), 32'h5);
      tick();
      tx_done = 1'b1;
      tick();
      check("arb_done2", 32'(mb_done), 32'h4);
      do_frame(3'd0, 11'h300);

      // Retry exhaustion: four starts then fail
      mb_id  = {11'h7FF, 11'h7FF, 11'h0AB, 11'h7FF};
      mb_req = 4'b0010;
      tick();
      for (int i = 0; i < 4; i++) begin
         wait_start();
         check("retry_sel", 32'(tx_sel), 32'd1);
         tick();
         tx_err = 1'b1;
         tick();
         check("retry_fail", 32'(mb_fail), (i == 3) ? 32'h2 : 32'h0);
      end
      check("retry_pend", 32'(mb_pending), 32'h0);
      count_starts(6, st);
      check("retry_nomore", 32'(st), 32'd0);

      // Abort of a non-active pending mailbox
      mb_id  = {11'h200, 11'h7FF, 11'h7FF, 11'h100};
      mb_req = 4'b1001;
      tick();
      wait_start();
      check("ab_act_sel", 32'(tx_sel), 32'd0);
      tick();
      mb_abort = 4'b1000;
      tick();
      check("ab_na_fail", 32'(mb_fail), 32'h8);
      check("ab_na_pend", 32'(mb_pending), 32'h1);
      tx_done = 1'b1;
      tick();
      check("ab_na_done0", 32'(mb_done), 32'h1);
      count_starts(6, st);
      check("ab_na_nostart", 32'(st), 32'd0);

      // Abort of the active mailbox, then done
      mb_req = 4'b0001;
      tick();
      wait_start();
      tick();
      mb_abort = 4'b0001;
      tick();
      check("ab_ad_nofail", 32'(mb_fail), 32'h0);
      check("ab_ad_pend", 32'(mb_pending), 32'h1);
      tx_done = 1'b1;
      tick();
      check("ab_ad_done", 32'(mb_done), 32'h1);
      check("ab_ad_fail", 32'(mb_fail), 32'h0);

      // Abort of the active mailbox, then error
      mb_req = 4'b0001;
      tick();
      wait_start();
      tick();
      mb_abort = 4'b0001;
      tick();
      tx_err = 1'b1;
      tick();
      check("ab_ae_fail", 32'(mb_fail), 32'h1);
      check("ab_ae_done", 32'(mb_done), 32'h0);
      check("ab_ae_pend", 32'(mb_pending), 32'h0);
      count_starts(6, st);
      check("ab_ae_nostart", 32'(st), 32'd0);

      // Request and abort in the same cycle
      mb_req   = 4'b0100;
      mb_abort = 4'b0100;
      tick();
      check("ab_same_pend", 32'(mb_pending), 32'h0);
      check("ab_same_fail", 32'(mb_fail), 32'h0);

      // Enable low holds the request pending
      en     = 1'b0;
      mb_req = 4'b0001;
      tick();
      count_starts(5, st);
      check("en_nostart", 32'(st), 32'd0);
      check("en_busy", 32'(busy), 32'd0);
      check("en_pend", 32'(mb_pending), 32'h1);
      en = 1'b1;
      do_frame(3'd0, 11'h100);

      // Reset while waiting on the engine
      mb_req = 4'b0001;
      tick();
      wait_start();
      tick();
      rst_n = 1'b0;
      tick();
      check("rw_start", 32'(tx_start), 32'd0);
      check("rw_sel", 32'(tx_sel), 32'd0);
      check("rw_id", 32'(tx_id), 32'd0);
      check("rw_pend", 32'(mb_pending), 32'h0);
      check("rw_busy", 32'(busy), 32'd0);
      check("rw_irq", 32'(irq), 32'd0);
      rst_n   = 1'b1;
      tx_done = 1'b1;
      tick();
      check("rw_done", 32'(mb_done), 32'h0);
      check("rw_fail", 32'(mb_fail), 32'h0);
      count_starts(5, st);
      check("rw_nostart", 32'(st), 32'd0);
      check("rw_busy2", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
